// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer for the RV32I datapath: owns the PC, fetches over a
// req/ack port, presents one instruction per EXEC cycle and halts on faults.
//
// state | meaning
// IDLE  | out of reset, waiting for the first clock edge
// FETCH | imem_req_o high at pc, waiting for imem_ack_i (timeout counted)
// EXEC  | instruction latched, datapath commits unless stalled
// HALT  | sticky stop after a misaligned redirect or fetch timeout
module fetch_sequencer #(
    parameter int                  XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter int                  MAX_WAIT = 15
) (
    input  logic            clk_i,
    input  logic            reset_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    input  logic            stall_i,
    input  logic            take_branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            halted_o,
    output logic [1:0]      fault_code_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [1:0]  FAULT_NONE  = 2'b00;
    localparam logic [1:0]  FAULT_ALIGN = 2'b01;
    localparam logic [1:0]  FAULT_TIME  = 2'b10;
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [7:0]  WAIT_LAST   = 8'(MAX_WAIT - 1);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [7:0]      wait_q, wait_d;
    logic [1:0]      fault_q, fault_d;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        fault_d = FAULT_TIME;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_EXEC: begin
                // stall has priority; a held redirect is simply re-sampled later
                if (!stall_i) begin
                    if (!take_branch_i) begin
                        pc_d    = pc_plus4;
                        state_d = ST_FETCH;
                    end else if (branch_target_i[1:0] == 2'b00) begin
                        pc_d    = branch_target_i;
                        state_d = ST_FETCH;
                    end else begin
                        fault_d = FAULT_ALIGN;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            wait_q  <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // Strobes come from state; stall only masks the commit strobe so a held EXEC never commits.
    assign imem_req_o    = (state_q == ST_FETCH);
    assign instr_valid_o = (state_q == ST_EXEC) && !stall_i;
    assign halted_o      = (state_q == ST_HALT);
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign instr_o       = instr_q;
    assign fault_code_o  = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, every cycle
// compared against a phase-flag reference model of the fetch/execute rules.
module tb_fetch_sequencer;

    localparam int MAX_WAIT = 15;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        stall_i;
    logic        take_branch_i;
    logic [31:0] branch_target_i;
    logic        halted_o;
    logic [1:0]  fault_code_o;

    always #5 clk_i = ~clk_i;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_o        (instr_o),
        .instr_valid_o  (instr_valid_o),
        .pc_o           (pc_o),
        .pc_plus4_o     (pc_plus4_o),
        .stall_i        (stall_i),
        .take_branch_i  (take_branch_i),
        .branch_target_i(branch_target_i),
        .halted_o       (halted_o),
        .fault_code_o   (fault_code_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: running / fetching / halted flags plus architectural values
    logic        m_started, m_fetching, m_halted;
    logic [31:0] m_pc, m_instr;
    logic [1:0]  m_fault;
    int          m_waits;

    task automatic model_reset();
        m_started  = 1'b0;
        m_fetching = 1'b0;
        m_halted   = 1'b0;
        m_pc       = 32'h0;
        m_instr    = 32'h0000_0013;
        m_fault    = 2'b00;
        m_waits    = 0;
    endtask

    task automatic check_outputs(input logic stl);
        logic executing;
        executing = m_started && !m_fetching && !m_halted;
        check_eq("imem_req", 32'(imem_req_o), 32'(m_started && m_fetching && !m_halted));
        check_eq("instr_valid", 32'(instr_valid_o), 32'(executing && !stl));
        check_eq("pc", pc_o, m_pc);
        check_eq("imem_addr", imem_addr_o, m_pc);
        check_eq("pc_plus4", pc_plus4_o, m_pc + 32'd4);
        check_eq("instr", instr_o, m_instr);
        check_eq("halted", 32'(halted_o), 32'(m_halted));
        check_eq("fault_code", 32'(fault_code_o), 32'(m_fault));
    endtask

    // Entered and left at a falling edge: drive, check, clock, advance model.
    task automatic step(input logic ack, input logic stl, input logic br, input logic [31:0] tgt);
        logic [31:0] rdata;
        rdata           = $urandom;
        imem_ack_i      = ack;
        stall_i         = stl;
        take_branch_i   = br;
        branch_target_i = tgt;
        imem_rdata_i    = rdata;
        #1;
        check_outputs(stl);
        @(posedge clk_i);
        if (!m_started) begin
            m_started  = 1'b1;
            m_fetching = 1'b1;
        end else if (m_halted) begin
            // frozen until reset
        end else if (m_fetching) begin
            if (ack) begin
                m_instr    = rdata;
                m_fetching = 1'b0;
                m_waits    = 0;
            end else begin
                m_waits++;
                if (m_waits == MAX_WAIT) begin
                    m_halted = 1'b1;
                    m_fault  = 2'b10;
                end
            end
        end else if (!stl) begin
            if (!br) begin
                m_pc       = m_pc + 32'd4;
                m_fetching = 1'b1;
            end else if (tgt % 4 == 0) begin
                m_pc       = tgt;
                m_fetching = 1'b1;
            end else begin
                m_halted = 1'b1;
                m_fault  = 2'b01;
            end
        end
        @(negedge clk_i);
    endtask

    // Reset lands mid-cycle; outputs must clear before any clock edge.
    task automatic pulse_reset();
        imem_ack_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("rst_req_async", 32'(imem_req_o), 32'd0);
        check_eq("rst_pc_async", pc_o, 32'h0);
        check_eq("rst_halted_async", 32'(halted_o), 32'd0);
        check_eq("rst_fault_async", 32'(fault_code_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i         = 1'b1;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 32'h0;
        stall_i         = 1'b0;
        take_branch_i   = 1'b0;
        branch_target_i = 32'h0;
        model_reset();
        @(negedge clk_i);
        check_outputs(1'b0);
        reset_i = 1'b0;

        // sequential NOPs with zero-wait memory
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        pulse_reset();

        // forward JAL at pc=4 -> 16, backward JAL at pc=20 -> 8
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("jal_pc_plus4", pc_plus4_o, 32'd8);
        step(1'b1, 1'b0, 1'b1, 32'd16);
        check_eq("jal_fetch_addr", imem_addr_o, 32'd16);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("bjal_pc_plus4", pc_plus4_o, 32'd24);
        step(1'b1, 1'b0, 1'b1, 32'd8);
        check_eq("bjal_fetch_addr", imem_addr_o, 32'd8);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // stall for three EXEC cycles with a redirect offered, then release
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("stall_release_pc", pc_o, 32'd12);

        // misaligned redirect halts; no requests afterwards
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_000A);
        check_eq("misalign_halt", 32'(halted_o), 32'd1);
        check_eq("misalign_fault", 32'(fault_code_o), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        pulse_reset();

        // timeout: 15 FETCH cycles without ack
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < MAX_WAIT; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("timeout_halt", 32'(halted_o), 32'd1);
        check_eq("timeout_fault", 32'(fault_code_o), 32'd2);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        pulse_reset();

        // ack on the last allowed wait cycle wins over the timeout
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < MAX_WAIT - 1; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("late_ack_no_halt", 32'(halted_o), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // pc+4 wraps to zero
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("wrap_pc_plus4", pc_plus4_o, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("wrap_pc", pc_o, 32'h0);

        // mid-FETCH reset with an ack pending, then a normal restart
        pulse_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        pulse_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            if (m_halted) pulse_reset();
            tgt = $urandom_range(0, 15) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, tgt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
